// File: rtl/core_pkg.sv
// Shared core definitions for the instruction fetch slice.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0) injected on flush
//   fetch_state_t : fetch FSM states
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Output register plus one-entry skid buffer between instruction memory and
// the IF/ID pipeline register.
//   clk, rst         : clock; synchronous active-low reset
//   flush            : redirect; drop everything and present a NOP
//   stall            : IF/ID is holding; current output must not change
//   rsp_valid        : accepted memory response this cycle
//   rsp_instr/rsp_pc : response word and the PC it was fetched from
//   out_instr/out_pc : presented instruction / PC
//   out_valid        : presented instruction is real
//   skid_valid       : skid entry occupied (fetch FSM must not issue)
module fetch_skid_buffer
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_instr,
    input  logic [XLEN-1:0] rsp_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_valid,
    output logic            skid_valid
);

    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;

    // Priority: flush > hold under stall > drain skid > new response > bubble.
    // Redirect deliberately beats stall so a killed instruction never lingers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_instr  <= NOP_INSTR;
            out_pc     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_instr  <= NOP_INSTR;
            out_pc     <= '0;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (stall && out_valid) begin
            // Output frozen; a response landing now is parked in the skid.
            // The FSM never issues while skid_valid, so it cannot be overwritten.
            if (rsp_valid) begin
                skid_valid <= 1'b1;
            end
        end else if (skid_valid) begin
            out_instr  <= skid_instr;
            out_pc     <= skid_pc;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
        end else if (rsp_valid) begin
            out_instr <= rsp_instr;
            out_pc    <= rsp_pc;
            out_valid <= 1'b1;
        end else begin
            out_instr <= NOP_INSTR;
            out_pc    <= '0;
            out_valid <= 1'b0;
        end
    end

    // Skid payload carries no control meaning on its own; no reset needed.
    always_ff @(posedge clk) begin
        if (rst && !flush && stall && out_valid && rsp_valid) begin
            skid_instr <= rsp_instr;
            skid_pc    <= rsp_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction memory
// request outstanding, and feeds instruction/PC pairs to IF/ID.
//   RESET_PC               : first fetch address after reset
//   clk, rst               : clock; synchronous active-low reset
//   stall                  : IF/ID hold from the hazard unit
//   redirect, redirect_pc  : taken branch/jump; target word-aligned here
//   imem_req, imem_addr    : fetch request / word address (combinational)
//   imem_gnt               : request accepted this cycle
//   imem_rvalid, imem_rdata: read response
//   if_instr, if_pc, if_valid : registered outputs to IF/ID
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_valid
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_pc_next;
    logic [XLEN-1:0] redirect_tgt;
    logic            skid_valid;
    logic            slot_free;
    logic            rsp_valid;

    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign slot_free    = !if_valid || !stall;
    assign imem_addr    = pc;
    // Only a response to a live request is forwarded; BOOT/ISSUE/DROP ignore rvalid.
    assign rsp_valid    = (state == WAIT) && imem_rvalid && !redirect;

    always_comb begin
        imem_req    = 1'b0;
        state_next  = state;
        pc_next     = pc;
        req_pc_next = req_pc;
        case (state)
            BOOT: begin
                state_next = ISSUE;
            end
            ISSUE: begin
                imem_req = !skid_valid;
                if (redirect) begin
                    // Address may change while ungranted; a granted request
                    // to the old PC is stale and must be drained in DROP.
                    pc_next = redirect_tgt;
                    if (imem_req && imem_gnt) begin
                        state_next = DROP;
                    end
                end else if (imem_req && imem_gnt) begin
                    state_next  = WAIT;
                    req_pc_next = pc;
                    pc_next     = pc + 32'd4;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_next    = redirect_tgt;
                    state_next = imem_rvalid ? ISSUE : DROP;
                end else if (imem_rvalid) begin
                    // Back-to-back issue only when the response has somewhere
                    // to go without occupying the skid entry.
                    imem_req = slot_free && !skid_valid;
                    if (imem_req && imem_gnt) begin
                        req_pc_next = pc;
                        pc_next     = pc + 32'd4;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_next = redirect_tgt;
                end
                if (imem_rvalid) begin
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        req_pc <= req_pc_next;
    end

    fetch_skid_buffer u_skid (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .stall      (stall),
        .rsp_valid  (rsp_valid),
        .rsp_instr  (imem_rdata),
        .rsp_pc     (req_pc),
        .out_instr  (if_instr),
        .out_pc     (if_pc),
        .out_valid  (if_valid),
        .skid_valid (skid_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a one-outstanding instruction memory
// model whose response latency is adjustable per grant. Memory word at
// address a is a ^ 32'h5A000000.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;

    int errors = 0;
    int checks = 0;

    // memory model
    int          lat = 1;
    int          cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;

    assign imem_gnt    = imem_req;
    assign imem_rvalid = pend && (cnt == 0);
    assign imem_rdata  = imem_rvalid ? (pend_addr ^ 32'h5A000000) : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (imem_rvalid) pend <= 1'b0;
        else if (pend) cnt <= cnt - 1;
        if (imem_gnt) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
            cnt       <= lat - 1;
        end
    end

    fetch_unit #(.RESET_PC(32'h00000000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_valid    (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle C0 (BOOT) with rst released.
    task automatic do_reset;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; lat = 1;
        repeat (4) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; lat = 1;
        repeat (4) tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", if_instr, NOP); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", if_pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b expected 0", imem_req); end
        tick();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_stream;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stream_req c%0d: got %b expected 0", i, imem_req); end
            end else begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i - 1))) begin errors++; $display("FAIL stream_addr c%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * (i - 1))); end
            end
            if (i >= 3) begin
                checks++; if (if_valid !== 1'b1 || if_pc !== 32'(4 * (i - 3)) || if_instr !== (32'(4 * (i - 3)) ^ 32'h5A000000)) begin errors++; $display("FAIL stream_out c%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h", i, if_valid, if_pc, if_instr, 32'(4 * (i - 3))); end
            end else begin
                checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_idle c%0d: got v=%b expected 0", i, if_valid); end
            end
            tick();
        end
    endtask

    task automatic test_stall;
        do_reset();
        repeat (4) tick();
        stall = 1'b1;
        for (int i = 4; i < 8; i++) begin
            if (i == 7) stall = 1'b0;
            @(negedge clk);
            checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h5A000004) begin errors++; $display("FAIL stall_hold c%0d: got v=%b pc=%h instr=%h expected v=1 pc=4 instr=5a000004", i, if_valid, if_pc, if_instr); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq c%0d: got %b expected 0", i, imem_req); end
            tick();
        end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h5A000008) begin errors++; $display("FAIL stall_skid_out: got v=%b pc=%h instr=%h expected v=1 pc=8", if_valid, if_pc, if_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_resume_req: got req=%b addr=%h expected req=1 addr=c", imem_req, imem_addr); end
        tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL stall_b2b_req: got req=%b addr=%h expected req=1 addr=10", imem_req, imem_addr); end
        tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'h5A00000C) begin errors++; $display("FAIL stall_next_out: got v=%b pc=%h instr=%h expected v=1 pc=c", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_late;
        do_reset();
        lat = 3;
        repeat (2) tick();
        redirect = 1'b1; redirect_pc = 32'h00000103;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdl_req_c2: got %b expected 0", imem_req); end
        tick();
        redirect = 1'b0; lat = 1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0) begin errors++; $display("FAIL rdl_nop: got v=%b instr=%h pc=%h expected v=0 instr=%h pc=0", if_valid, if_instr, if_pc, NOP); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdl_drop_req_c3: got %b expected 0", imem_req); end
        tick();
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rdl_stale_c4: got req=%b v=%b expected req=0 v=0", imem_req, if_valid); end
        tick();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdl_target_req: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rdl_stale_out: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        repeat (2) tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h5A000100) begin errors++; $display("FAIL rdl_target_out: got v=%b pc=%h instr=%h expected v=1 pc=100", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_with_rvalid;
        do_reset();
        repeat (2) tick();
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFE;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rdv_req: got %b expected 0", imem_req); end
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL rdv_target_req: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rdv_discard: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        tick();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rdv_wrap_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFFFFFC || if_instr !== 32'hA5FFFFFC) begin errors++; $display("FAIL rdv_target_out: got v=%b pc=%h instr=%h expected v=1 pc=fffffffc instr=a5fffffc", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_stall_skid;
        do_reset();
        repeat (4) tick();
        stall = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h00000300;
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || imem_req !== 1'b0) begin errors++; $display("FAIL rss_pre: got v=%b pc=%h req=%b expected v=1 pc=4 req=0", if_valid, if_pc, imem_req); end
        tick();
        redirect = 1'b0; stall = 1'b0;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP) begin errors++; $display("FAIL rss_nop: got v=%b instr=%h expected v=0 instr=%h", if_valid, if_instr, NOP); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL rss_req: got req=%b addr=%h expected req=1 addr=300", imem_req, imem_addr); end
        tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rss_skid_cleared: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h300 || if_instr !== 32'h5A000300) begin errors++; $display("FAIL rss_target_out: got v=%b pc=%h instr=%h expected v=1 pc=300", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        repeat (2) tick();
        lat = 2;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rmw_pre: got v=%b pc=%h req=%b expected v=1 pc=0 req=0", if_valid, if_pc, imem_req); end
        tick();
        rst = 1'b1; lat = 1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0 || imem_req !== 1'b0) begin errors++; $display("FAIL rmw_reset: got v=%b instr=%h pc=%h req=%b expected v=0 instr=%h pc=0 req=0", if_valid, if_instr, if_pc, imem_req, NOP); end
        tick();
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmw_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rmw_ignored: got v=%b pc=%h expected v=0", if_valid, if_pc); end
        tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rmw_c6: got v=%b expected v=0", if_valid); end
        tick();
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h5A000000) begin errors++; $display("FAIL rmw_out: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=5a000000", if_valid, if_pc, if_instr); end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_late();
        test_redirect_with_rvalid();
        test_redirect_stall_skid();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
